// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS32 control sequencer:
// opcodes, state encoding and the datapath mux/ALU control codes.
package mc_ctrl_pkg;

   // Opcodes (IR[31:26]) understood by the sequencer
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   // Sequencer states; IDLE and ERROR sit at the ends of the 4-bit range
   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      ALUWB  = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      BRANCH = 4'd11,
      JUMP   = 4'd12,
      ERROR  = 4'd15
   } state_t;

   // ALU operation select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;

   // ALU B operand select
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // Register file write address select
   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   // Register file write data select
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   // Next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that own the shared memory port and wait on mem_ready
   function automatic logic is_mem_state(state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Datapath-facing bundle of the control sequencer.
// Handshake: the sequencer raises MemRead or MemWrite and holds it, together
// with IorD, until a cycle in which mem_ready is 1; that cycle completes the
// access. mem_ready in any cycle without a request is ignored.
interface multicycle_ctrl_fsm_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] RegDst;
   logic [1:0] MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;

   // Sequencer side: takes opcode/mem_ready, drives the control strobes
   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
   );

   // Datapath/memory side
   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; saturates at TIMEOUT and flags it.
module mem_wait_timer #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   // Clear has priority; increment stops at LIMIT so expired stays asserted
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != LIMIT))
         count <= count + 1'b1;
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS32 control sequencer: steps the shared memory port, ALU
// and IR/PC through FETCH/DECODE/EXEC/MEM/WB, stalling on mem_ready and
// locking into ERROR when a memory access waits too long.
module multicycle_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   multicycle_ctrl_fsm_if.master       bus,
   output logic                        illegal_op,
   output logic                        mem_err,
   output logic [3:0]                  state_o
);

   state_t           state, next_state;
   logic             jal_q, sw_q;
   logic             in_mem, wait_clr, wait_inc, wait_expired;
   logic [CNT_W-1:0] wait_count;
   logic             unused_wait_count;

   assign in_mem   = is_mem_state(state);
   // Cleared whenever not waiting, so every memory state is entered at zero
   assign wait_clr = !in_mem || bus.mem_ready;
   assign wait_inc = in_mem && !bus.mem_ready;
   assign state_o  = state;
   assign unused_wait_count = ^wait_count;

   mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wait (
      .clk     (clk),
      .reset   (reset),
      .clr     (wait_clr),
      .inc     (wait_inc),
      .count   (wait_count),
      .expired (wait_expired)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Instruction flags captured in DECODE for the later MEMADR/JUMP steps
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jal_q <= 1'b0;
         sw_q  <= 1'b0;
      end else if (state == DECODE) begin
         jal_q <= (bus.opcode == OP_JAL);
         sw_q  <= (bus.opcode == OP_SW);
      end
   end

   // Next-state and control strobes; everything defaults to inactive
   always_comb begin
      next_state       = state;
      bus.PCWrite      = 1'b0;
      bus.PCWriteCond  = 1'b0;
      bus.IorD         = 1'b0;
      bus.MemRead      = 1'b0;
      bus.MemWrite     = 1'b0;
      bus.IRWrite      = 1'b0;
      bus.RegDst       = REGDST_RT;
      bus.MemtoReg     = M2R_ALUOUT;
      bus.RegWrite     = 1'b0;
      bus.ALUSrcA      = 1'b0;
      bus.ALUSrcB      = SRCB_RT;
      bus.ALUOp        = ALUOP_ADD;
      bus.PCSource     = PCSRC_ALU;
      illegal_op       = 1'b0;
      mem_err          = 1'b0;
      case (state)
         IDLE: next_state = FETCH;
         FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = SRCB_FOUR;
            bus.IRWrite = bus.mem_ready;
            bus.PCWrite = bus.mem_ready;
            if (bus.mem_ready)   next_state = DECODE;
            else if (wait_expired) next_state = ERROR;
         end
         DECODE: begin
            bus.ALUSrcB = SRCB_IMM_SH;
            case (bus.opcode)
               OP_LW, OP_SW:  next_state = MEMADR;
               OP_R:          next_state = EXEC;
               OP_ADDI:       next_state = ADDIEX;
               OP_BEQ:        next_state = BRANCH;
               OP_J, OP_JAL:  next_state = JUMP;
               default: begin
                  next_state = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = SRCB_IMM;
            next_state  = sw_q ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
            if (bus.mem_ready)     next_state = MEMWB;
            else if (wait_expired) next_state = ERROR;
         end
         MEMWB: begin
            bus.MemtoReg = M2R_MDR;
            bus.RegWrite = 1'b1;
            next_state   = FETCH;
         end
         MEMWR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
            if (bus.mem_ready)     next_state = FETCH;
            else if (wait_expired) next_state = ERROR;
         end
         EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = ALUOP_FUNCT;
            next_state  = ALUWB;
         end
         ALUWB: begin
            bus.RegDst   = REGDST_RD;
            bus.RegWrite = 1'b1;
            next_state   = FETCH;
         end
         ADDIEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = SRCB_IMM;
            bus.ALUOp   = ALUOP_ADDI;
            next_state  = ADDIWB;
         end
         ADDIWB: begin
            bus.RegWrite = 1'b1;
            next_state   = FETCH;
         end
         BRANCH: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = ALUOP_SUB;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = PCSRC_ALUOUT;
            next_state      = FETCH;
         end
         JUMP: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = PCSRC_JUMP;
            if (jal_q) begin
               bus.RegDst   = REGDST_RA;
               bus.MemtoReg = M2R_PC;
               bus.RegWrite = 1'b1;
            end
            next_state = FETCH;
         end
         ERROR: mem_err = 1'b1;
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: vector table, hand-written corner
// sequences (stalls, timeout, async reset) and randomized instruction streams.
module tb_multicycle_ctrl_fsm;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic       pcw, pcwc, iord, mrd, mwr, irw;
      logic [1:0] regdst, memtoreg;
      logic       regw, srca;
      logic [1:0] srcb, aluop, pcsrc;
      logic       ill, err;
   } ctl_t;

   typedef struct {
      logic [5:0] op;
      logic       rdy;
      state_t     st;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       illegal_op, mem_err;
   logic [3:0] state_o;
   int         total = 0;
   int         bad = 0;
   vec_t       vq[$];
   state_t     recipe[$];

   multicycle_ctrl_fsm_if bus();

   multicycle_ctrl_fsm #(.TIMEOUT(15), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .illegal_op (illegal_op),
      .mem_err    (mem_err),
      .state_o    (state_o)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic ctl_t get_ctl();
      ctl_t c;
      c.pcw = bus.PCWrite;   c.pcwc = bus.PCWriteCond; c.iord = bus.IorD;
      c.mrd = bus.MemRead;   c.mwr = bus.MemWrite;     c.irw = bus.IRWrite;
      c.regdst = bus.RegDst; c.memtoreg = bus.MemtoReg; c.regw = bus.RegWrite;
      c.srca = bus.ALUSrcA;  c.srcb = bus.ALUSrcB;     c.aluop = bus.ALUOp;
      c.pcsrc = bus.PCSource; c.ill = illegal_op;      c.err = mem_err;
      return c;
   endfunction

   // Control word each step must show, taken from the sequencer's step table
   function automatic ctl_t exp_ctl(state_t s, logic rdy, logic [5:0] op, logic jal);
      ctl_t c = '0;
      case (s)
         FETCH:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
         DECODE: begin
            c.srcb = 2'b11;
            c.ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000,
                                 6'b000100, 6'b000010, 6'b000011});
         end
         MEMADR: begin c.srca = 1; c.srcb = 2'b10; end
         MEMRD:  begin c.mrd = 1; c.iord = 1; end
         MEMWB:  begin c.memtoreg = 2'b01; c.regw = 1; end
         MEMWR:  begin c.mwr = 1; c.iord = 1; end
         EXEC:   begin c.srca = 1; c.aluop = 2'b10; end
         ALUWB:  begin c.regdst = 2'b01; c.regw = 1; end
         ADDIEX: begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b11; end
         ADDIWB: begin c.regw = 1; end
         BRANCH: begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
         JUMP: begin
            c.pcw = 1; c.pcsrc = 2'b10;
            if (jal) begin c.regdst = 2'b10; c.memtoreg = 2'b10; c.regw = 1; end
         end
         ERROR:  c.err = 1;
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: drive at negedge, compare state and full control word
   task automatic run_cycle(input logic [5:0] op, input logic rdy, input state_t est,
                            input logic jal, input string nm);
      @(negedge clk);
      bus.opcode = op;
      bus.mem_ready = rdy;
      #1;
      chk({nm, " state"}, 32'(state_o), 32'(est));
      chk({nm, " ctl"}, 32'(get_ctl()), 32'(exp_ctl(est, rdy, op, jal)));
   endtask

   // Reset for 2 cycles; returns with DUT in IDLE, next cycle is FETCH
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode = 6'h00;
      #1;
      chk("reset state", 32'(state_o), 32'(IDLE));
      chk("reset ctl", 32'(get_ctl()), 32'd0);
      @(negedge clk);
      #1;
      chk("reset ctl 2", 32'(get_ctl()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("idle after reset", 32'(state_o), 32'(IDLE));
      chk("idle ctl", 32'(get_ctl()), 32'd0);
   endtask

   task automatic add(input logic [5:0] op, input logic rdy, input state_t st);
      vec_t v;
      v.op = op; v.rdy = rdy; v.st = st;
      vq.push_back(v);
   endtask

   task automatic build_recipe(input logic [5:0] op);
      recipe.delete();
      recipe.push_back(FETCH);
      recipe.push_back(DECODE);
      case (op)
         OP_LW:   begin recipe.push_back(MEMADR); recipe.push_back(MEMRD); recipe.push_back(MEMWB); end
         OP_SW:   begin recipe.push_back(MEMADR); recipe.push_back(MEMWR); end
         OP_R:    begin recipe.push_back(EXEC);   recipe.push_back(ALUWB); end
         OP_ADDI: begin recipe.push_back(ADDIEX); recipe.push_back(ADDIWB); end
         OP_BEQ:  recipe.push_back(BRANCH);
         OP_J, OP_JAL: recipe.push_back(JUMP);
         default: ;
      endcase
   endtask

   initial begin
      logic       last_jal;
      logic [5:0] op;
      int         stall;

      bus.opcode = 6'h00;
      bus.mem_ready = 1'b1;

      // Vector table: one instruction of each kind plus a fetch and a read stall
      add(OP_LW, 1, FETCH); add(OP_LW, 1, DECODE); add(6'h3F, 1, MEMADR);
      add(6'h3F, 1, MEMRD); add(6'h3F, 1, MEMWB);
      add(OP_SW, 1, FETCH); add(OP_SW, 1, DECODE); add(OP_BEQ, 1, MEMADR); add(6'h00, 1, MEMWR);
      add(OP_LW, 1, FETCH); add(OP_R, 1, DECODE); add(OP_J, 0, EXEC); add(OP_J, 0, ALUWB);
      add(OP_R, 1, FETCH); add(OP_ADDI, 1, DECODE); add(OP_R, 1, ADDIEX); add(OP_R, 1, ADDIWB);
      add(OP_R, 1, FETCH); add(OP_BEQ, 1, DECODE); add(OP_LW, 1, BRANCH);
      add(OP_R, 1, FETCH); add(OP_J, 1, DECODE); add(OP_JAL, 1, JUMP);
      add(OP_R, 1, FETCH); add(OP_JAL, 1, DECODE); add(OP_J, 1, JUMP);
      add(OP_R, 1, FETCH); add(6'h3F, 1, DECODE);
      add(OP_R, 0, FETCH); add(OP_R, 0, FETCH); add(OP_R, 0, FETCH); add(OP_R, 1, FETCH);
      add(OP_BEQ, 1, DECODE); add(OP_R, 1, BRANCH);
      add(OP_R, 1, FETCH); add(OP_LW, 1, DECODE); add(OP_R, 0, MEMADR);
      add(OP_R, 0, MEMRD); add(OP_R, 0, MEMRD); add(OP_R, 1, MEMRD); add(OP_R, 0, MEMWB);
      add(OP_R, 1, FETCH);

      do_reset();
      last_jal = 1'b0;
      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].st == DECODE) last_jal = (vq[i].op == OP_JAL);
         run_cycle(vq[i].op, vq[i].rdy, vq[i].st, last_jal, $sformatf("vec%0d", i));
      end

      // Counter clears on mem_ready: 10-cycle fetch stall then 15-cycle read stall
      do_reset();
      repeat (10) run_cycle(OP_R, 0, FETCH, 0, "clr fetch stall");
      run_cycle(OP_R, 1, FETCH, 0, "clr fetch done");
      run_cycle(OP_LW, 1, DECODE, 0, "clr decode");
      run_cycle(OP_R, 1, MEMADR, 0, "clr memadr");
      repeat (15) run_cycle(OP_R, 0, MEMRD, 0, "clr rd stall");
      run_cycle(OP_R, 1, MEMRD, 0, "clr rd done");
      run_cycle(OP_R, 1, MEMWB, 0, "clr memwb");
      run_cycle(OP_R, 1, FETCH, 0, "clr refetch");

      // Boundary: 15 write stalls then ready on the 16th cycle, no error
      do_reset();
      run_cycle(OP_R, 1, FETCH, 0, "edge fetch");
      run_cycle(OP_SW, 1, DECODE, 0, "edge decode");
      run_cycle(OP_R, 1, MEMADR, 0, "edge memadr");
      repeat (15) run_cycle(OP_R, 0, MEMWR, 0, "edge wr stall");
      run_cycle(OP_R, 1, MEMWR, 0, "edge wr done");
      run_cycle(OP_R, 1, FETCH, 0, "edge refetch");

      // Timeout: 16 write stalls -> ERROR, sticky even once mem_ready returns
      do_reset();
      run_cycle(OP_R, 1, FETCH, 0, "to fetch");
      run_cycle(OP_SW, 1, DECODE, 0, "to decode");
      run_cycle(OP_R, 1, MEMADR, 0, "to memadr");
      repeat (16) run_cycle(OP_R, 0, MEMWR, 0, "to wr stall");
      run_cycle(OP_R, 0, ERROR, 0, "to error");
      chk("to mem_err", 32'(mem_err), 32'd1);
      chk("to memwrite", 32'(bus.MemWrite), 32'd0);
      repeat (3) run_cycle(OP_SW, 1, ERROR, 0, "to sticky");

      // Async reset in the middle of a write stall takes effect before any edge
      do_reset();
      run_cycle(OP_R, 1, FETCH, 0, "ar fetch");
      run_cycle(OP_SW, 1, DECODE, 0, "ar decode");
      run_cycle(OP_R, 1, MEMADR, 0, "ar memadr");
      repeat (5) run_cycle(OP_R, 0, MEMWR, 0, "ar wr stall");
      #2;
      reset = 1'b1;
      #1;
      chk("ar state", 32'(state_o), 32'(IDLE));
      chk("ar memwrite", 32'(bus.MemWrite), 32'd0);
      chk("ar ctl", 32'(get_ctl()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      chk("ar idle", 32'(state_o), 32'(IDLE));
      run_cycle(OP_R, 1, FETCH, 0, "ar restart");

      // Random instruction stream with random stalls and junk opcodes/mem_ready
      do_reset();
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 8))
            0: op = OP_LW;   1: op = OP_SW;  2: op = OP_R;   3: op = OP_ADDI;
            4: op = OP_BEQ;  5: op = OP_J;   6: op = OP_JAL;
            default: begin
               do op = 6'($urandom);
               while (op inside {OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ, OP_J, OP_JAL});
            end
         endcase
         build_recipe(op);
         for (int s = 0; s < recipe.size(); s++) begin
            if (recipe[s] == FETCH || recipe[s] == MEMRD || recipe[s] == MEMWR) begin
               stall = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
               repeat (stall) run_cycle(6'($urandom), 0, recipe[s], op == OP_JAL, "rnd stall");
               run_cycle(6'($urandom), 1, recipe[s], op == OP_JAL, "rnd mem");
            end else if (recipe[s] == DECODE) begin
               run_cycle(op, 1'($urandom), DECODE, op == OP_JAL, "rnd decode");
            end else begin
               run_cycle(6'($urandom), 1'($urandom), recipe[s], op == OP_JAL, "rnd step");
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
